// File: rtl/safas_pkg.sv
// Shared types and helpers for the task dispatcher: task/deadline widths, FSM state
// encoding, and deadline field extract/insert on a task word.
package safas_pkg;

  localparam int TASK_W = 40;
  localparam int DL_W   = 16;

  typedef enum logic [1:0] {IDLE, POP, OFFER, SETTLE} dispatch_state_t;

  // Task word is carried in a 64-bit container so the helpers serve any TASK_W <= 64.
  function automatic logic [63:0] dl_get(input logic [63:0] t, input int tw, input int dw);
    logic [63:0] m;
    m = (64'd1 << dw) - 64'd1;
    return (t >> (tw - dw)) & m;
  endfunction

  function automatic logic [63:0] dl_put(input logic [63:0] t, input logic [63:0] d,
                                         input int tw, input int dw);
    logic [63:0] m;
    m = ((64'd1 << dw) - 64'd1) << (tw - dw);
    return (t & ~m) | ((d << (tw - dw)) & m);
  endfunction

endpackage

// File: rtl/task_dispatcher_rr_arbiter.sv
// Combinational round-robin arbiter: first set req bit at or after ptr, wrapping NC-1 -> 0.
module rr_arbiter #(
  parameter  int NC = 4,
  localparam int PW = (NC > 1) ? $clog2(NC) : 1
) (
  input  logic [NC-1:0] req,
  input  logic [PW-1:0] ptr,
  output logic [NC-1:0] gnt
);

  always_comb begin
    logic          found;
    logic [PW-1:0] idx;
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NC; i++) begin
      idx = PW'((int'(ptr) + i) % NC);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/task_dispatcher.sv
// Pops the earliest-deadline task from the insertion queue and offers it to one idle core.
// Optional expired-task drop is enabled with `define DISPATCH_MISS_DROP_EN.
module task_dispatcher #(
  parameter int W    = 41,
  parameter int DL_W = 16,
  parameter int NC   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-2:0]  q_data,
  input  logic          q_empty,
  output logic          q_rd,
  input  logic          subtract,
  input  logic [NC-1:0] core_idle,
  input  logic [NC-1:0] core_rdy,
  output logic [NC-1:0] core_vld,
  output logic [W-2:0]  core_task,
  output logic          busy,
  output logic          miss_pulse,
  output logic [15:0]   miss_cnt
);
  import safas_pkg::*;

  localparam int TW = W - 1;
  localparam int PW = (NC > 1) ? $clog2(NC) : 1;

  dispatch_state_t state, nxt;
  logic [TW-1:0]   hold_reg;
  logic [NC-1:0]   tgt, gnt;
  logic [PW-1:0]   rr_ptr, rr_nxt;
  logic [DL_W-1:0] hold_dl;
  logic            latch, accept, age, drop;

  rr_arbiter #(.NC(NC)) u_arb (.req(core_idle), .ptr(rr_ptr), .gnt(gnt));

  assign hold_dl = DL_W'(dl_get(64'(hold_reg), TW, DL_W));
  assign latch   = (state == IDLE) && !q_empty && |core_idle;
  assign accept  = (state == OFFER) && |(core_rdy & tgt);
  // The queue ages its own contents on the latch cycle, so only POP/OFFER age hold_reg.
  assign age     = subtract && ((state == POP) || (state == OFFER));

`ifdef DISPATCH_MISS_DROP_EN
  assign drop = (state == POP) && (hold_dl == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            miss_cnt <= '0;
    else if (drop && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
  end
`else
  assign drop     = 1'b0;
  assign miss_cnt = '0;
`endif

  assign q_rd       = latch;
  assign miss_pulse = drop;
  assign busy       = (state != IDLE);
  assign core_vld   = (state == OFFER) ? tgt : '0;
  assign core_task  = (state == OFFER) ? hold_reg : '0;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (latch) nxt = POP;
      POP:     nxt = drop ? SETTLE : OFFER;
      OFFER:   if (accept) nxt = SETTLE;
      SETTLE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    rr_nxt = '0;
    for (int i = 0; i < NC; i++)
      if (tgt[i]) rr_nxt = (i == NC - 1) ? '0 : PW'(i + 1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_reg <= '0;
      tgt      <= '0;
      rr_ptr   <= '0;
    end else begin
      if (latch) begin
        hold_reg <= q_data;
        tgt      <= gnt;
      end else if (age && hold_dl != '0) begin
        hold_reg <= TW'(dl_put(64'(hold_reg), 64'(hold_dl - 1'b1), TW, DL_W));
      end
      if (accept) rr_ptr <= rr_nxt;
    end
  end

endmodule

// File: tb/tb_task_dispatcher.sv
// Scoreboard bench for task_dispatcher: a bench-side queue model feeds q_data, expected
// (core, task) pairs are queued at stimulus time and matched against observed handshakes.
module tb_task_dispatcher;
  localparam int W = 41, TW = 40, DLW = 16, IDW = TW - DLW, NC = 4;

  logic          clk = 1'b0, rst = 1'b0;
  logic [TW-1:0] q_data = '0;
  logic          q_empty = 1'b1, q_rd, subtract = 1'b0;
  logic [NC-1:0] core_idle = '0, core_rdy = '0, core_vld;
  logic [TW-1:0] core_task;
  logic          busy, miss_pulse;
  logic [15:0]   miss_cnt;

  always #5 clk = ~clk;

  task_dispatcher #(.W(W), .DL_W(DLW), .NC(NC)) dut (
    .clk(clk), .rst(rst), .q_data(q_data), .q_empty(q_empty), .q_rd(q_rd),
    .subtract(subtract), .core_idle(core_idle), .core_rdy(core_rdy),
    .core_vld(core_vld), .core_task(core_task), .busy(busy),
    .miss_pulse(miss_pulse), .miss_cnt(miss_cnt));

  int n_checks = 0, n_fail = 0, cyc = 0, rd_consec = 0, vld_seen = 0, miss_seen = 0;
  bit prev_rd = 1'b0;
  logic [TW-1:0] mq[$];
  int            obs_core[$], exp_core[$], rd_cyc[$];
  logic [TW-1:0] obs_task[$], exp_task[$];

  function automatic logic [TW-1:0] mk(input int dl, input int id);
    return {DLW'(dl), IDW'(id)};
  endfunction

  function automatic void q_refresh();
    q_empty = (mq.size() == 0);
    q_data  = q_empty ? '0 : mq[0];
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [TW-1:0] t, input int core);
    mq.push_back(t);
    q_refresh();
    exp_core.push_back(core);
    exp_task.push_back(t);
  endtask

  task automatic wait_obs(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (obs_core.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; subtract = 1'b0; core_rdy = '0; core_idle = '0;
    mq.delete(); q_refresh();
    step(2);
    obs_core.delete(); obs_task.delete(); exp_core.delete(); exp_task.delete();
    rd_cyc.delete(); rd_consec = 0; vld_seen = 0; miss_seen = 0; prev_rd = 1'b0;
    rst = 1'b1;
    step();
  endtask

  // Queue model: pops on q_rd and ages remaining entries on subtract, as the insertion queue does.
  always @(posedge clk) begin
    bit rd_s, sub_s;
    logic [TW-1:0] tmp;
    cyc++;
    rd_s = q_rd; sub_s = subtract;
    #1;
    if (rd_s && mq.size() > 0) void'(mq.pop_front());
    if (sub_s)
      for (int i = 0; i < mq.size(); i++) begin
        tmp = mq[i];
        if (tmp[TW-1 -: DLW] != '0) tmp[TW-1 -: DLW] = tmp[TW-1 -: DLW] - 1'b1;
        mq[i] = tmp;
      end
    q_refresh();
  end

  always @(negedge clk) begin
    if (rst) begin
      if (|(core_vld & core_rdy)) begin
        int c;
        c = -1;
        for (int i = 0; i < NC; i++) if (core_vld[i]) c = i;
        obs_core.push_back(c);
        obs_task.push_back(core_task);
      end
      if (q_rd) begin
        rd_cyc.push_back(cyc);
        if (prev_rd) rd_consec++;
      end
      prev_rd = q_rd;
      if (|core_vld) vld_seen++;
      if (miss_pulse) miss_seen++;
    end
  end

  task automatic test_reset();
    step(2);
    @(negedge clk);
    n_checks++;
    if ({q_rd, core_vld, busy, miss_pulse} !== '0 || core_task !== '0 || miss_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_values: q_rd=%b vld=%b busy=%b miss=%b task=%h cnt=%h, required all 0",
               q_rd, core_vld, busy, miss_pulse, core_task, miss_cnt);
    end
    step();
    rst = 1'b1; core_idle = 4'hF;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (q_rd !== 1'b0 || core_vld !== '0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL empty_idle cyc%0d: q_rd=%b vld=%b busy=%b, required 0", i, q_rd, core_vld, busy);
      end
    end
    step();
    core_idle = '0;
  endtask

  task automatic test_single();
    bit ok;
    int c, ec;
    logic [TW-1:0] t, et;
    core_idle = 4'b0100; core_rdy = 4'b0100;
    push(mk(100, 'h123), 2);
    @(negedge clk);
    n_checks++;
    if (q_rd !== 1'b1) begin n_fail++; $display("FAIL single_qrd: got %b required 1", q_rd); end
    @(negedge clk);
    n_checks++;
    if (q_rd !== 1'b0 || core_vld !== '0) begin
      n_fail++; $display("FAIL single_pop: q_rd=%b vld=%b required 0/0", q_rd, core_vld);
    end
    @(negedge clk);
    n_checks++;
    if (core_vld !== 4'b0100 || core_task !== mk(100, 'h123)) begin
      n_fail++; $display("FAIL single_offer: vld=%b task=%h required 0100 %h", core_vld, core_task, mk(100, 'h123));
    end
    wait_obs(1, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_timeout: no handshake, required 1"); end
    while (obs_core.size() > 0 && exp_core.size() > 0) begin
      c = obs_core.pop_front(); t = obs_task.pop_front(); ec = exp_core.pop_front(); et = exp_task.pop_front();
      n_checks++;
      if (c !== ec || t !== et) begin
        n_fail++; $display("FAIL single_sb: core %0d task %h, required core %0d task %h", c, t, ec, et);
      end
    end
    step(3);
    n_checks++;
    if (rd_cyc.size() != 1) begin n_fail++; $display("FAIL single_rd_count: got %0d required 1", rd_cyc.size()); end
    core_idle = '0; core_rdy = '0;
  endtask

  task automatic test_round_robin();
    bit ok;
    int c, ec;
    logic [TW-1:0] t, et;
    do_reset();
    core_idle = 4'hF; core_rdy = 4'hF;
    for (int i = 0; i < 5; i++) push(mk(10 + i, 'hA0 + i), i % NC);
    wait_obs(5, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rr_timeout: got %0d handshakes required 5", obs_core.size()); end
    while (obs_core.size() > 0 && exp_core.size() > 0) begin
      c = obs_core.pop_front(); t = obs_task.pop_front(); ec = exp_core.pop_front(); et = exp_task.pop_front();
      n_checks++;
      if (c !== ec || t !== et) begin
        n_fail++; $display("FAIL rr_sb: core %0d task %h, required core %0d task %h", c, t, ec, et);
      end
    end
    step(2);
    n_checks++;
    if (rd_cyc.size() != 5 || rd_consec != 0) begin
      n_fail++; $display("FAIL rr_rd_count: pops %0d back-to-back %0d, required 5 and 0", rd_cyc.size(), rd_consec);
    end
    for (int i = 1; i < rd_cyc.size(); i++) begin
      n_checks++;
      if (rd_cyc[i] - rd_cyc[i-1] != 4) begin
        n_fail++; $display("FAIL rr_spacing %0d: got %0d cycles required 4", i, rd_cyc[i] - rd_cyc[i-1]);
      end
    end
    core_idle = '0; core_rdy = '0;
  endtask

  task automatic test_aging();
    bit ok;
    int c, ec;
    logic [TW-1:0] t, et;
    core_idle = 4'b0010; core_rdy = '0;
    mq.push_back(mk(3, 'h3C3)); q_refresh();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (|core_vld) break;
    end
    step();
    subtract = 1'b1;
    step(5);
    subtract = 1'b0;
    @(negedge clk);
    n_checks++;
    if (core_vld !== 4'b0010 || core_task !== mk(0, 'h3C3)) begin
      n_fail++; $display("FAIL aging_saturate: vld=%b task=%h required 0010 %h", core_vld, core_task, mk(0, 'h3C3));
    end
    step();
    exp_core.push_back(1); exp_task.push_back(mk(0, 'h3C3));
    core_rdy = 4'b0010;
    wait_obs(1, ok);
    step(2);
    // subtract on the latch edge: the queue ages, the held copy must not
    push(mk(50, 'h55), 1);
    subtract = 1'b1;
    step();
    subtract = 1'b0;
    wait_obs(2, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL aging_timeout: got %0d handshakes required 2", obs_core.size()); end
    while (obs_core.size() > 0 && exp_core.size() > 0) begin
      c = obs_core.pop_front(); t = obs_task.pop_front(); ec = exp_core.pop_front(); et = exp_task.pop_front();
      n_checks++;
      if (c !== ec || t !== et) begin
        n_fail++; $display("FAIL aging_sb: core %0d task %h, required core %0d task %h", c, t, ec, et);
      end
    end
    core_idle = '0; core_rdy = '0;
  endtask

  task automatic test_miss();
    do_reset();
    core_idle = 4'b1000; core_rdy = 4'b1000;
`ifdef DISPATCH_MISS_DROP_EN
    mq.push_back(mk(0, 'h77)); q_refresh();
    step(8);
    n_checks++;
    if (rd_cyc.size() != 1 || vld_seen != 0 || miss_seen != 1 || miss_cnt !== 16'd1) begin
      n_fail++; $display("FAIL miss_drop: pops %0d offers %0d pulses %0d cnt %0d, required 1 0 1 1",
                         rd_cyc.size(), vld_seen, miss_seen, miss_cnt);
    end
    mq.push_back(mk(0, 'h78)); q_refresh();
    step(8);
    n_checks++;
    if (miss_seen != 2 || miss_cnt !== 16'd2 || obs_core.size() != 0) begin
      n_fail++; $display("FAIL miss_second: pulses %0d cnt %0d handshakes %0d, required 2 2 0",
                         miss_seen, miss_cnt, obs_core.size());
    end
`else
    begin
      bit ok;
      int c, ec;
      logic [TW-1:0] t, et;
      push(mk(0, 'h77), 3);
      wait_obs(1, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL miss_offer_timeout: no handshake, required 1"); end
      while (obs_core.size() > 0 && exp_core.size() > 0) begin
        c = obs_core.pop_front(); t = obs_task.pop_front(); ec = exp_core.pop_front(); et = exp_task.pop_front();
        n_checks++;
        if (c !== ec || t !== et) begin
          n_fail++; $display("FAIL miss_sb: core %0d task %h, required core %0d task %h", c, t, ec, et);
        end
      end
      step(2);
      n_checks++;
      if (miss_seen != 0 || miss_cnt !== '0) begin
        n_fail++; $display("FAIL miss_tied: pulses %0d cnt %0d, required 0 0", miss_seen, miss_cnt);
      end
    end
`endif
    core_idle = '0; core_rdy = '0;
  endtask

  task automatic test_reset_mid_offer();
    bit ok;
    int c, ec;
    logic [TW-1:0] t, et;
    core_idle = 4'b0010; core_rdy = 4'b0010;
    push(mk(20, 'h61), 1);
    wait_obs(1, ok);
    core_rdy = '0; core_idle = 4'hF;
    step(2);
    mq.push_back(mk(30, 'h62)); q_refresh();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (|core_vld) break;
    end
    n_checks++;
    if (core_vld !== 4'b0100) begin n_fail++; $display("FAIL abort_offer: vld=%b required 0100", core_vld); end
    step();
    rst = 1'b0;
    #1;
    n_checks++;
    if (core_vld !== '0 || busy !== 1'b0 || q_rd !== 1'b0) begin
      n_fail++; $display("FAIL abort_async: vld=%b busy=%b q_rd=%b required 0", core_vld, busy, q_rd);
    end
    step();
    rst = 1'b1;
    mq.delete(); q_refresh();
    step();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b required 0", busy); end
    core_rdy = 4'hF;
    push(mk(40, 'h63), 0);
    wait_obs(2, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL abort_timeout: got %0d handshakes required 2", obs_core.size()); end
    while (obs_core.size() > 0 && exp_core.size() > 0) begin
      c = obs_core.pop_front(); t = obs_task.pop_front(); ec = exp_core.pop_front(); et = exp_task.pop_front();
      n_checks++;
      if (c !== ec || t !== et) begin
        n_fail++; $display("FAIL abort_sb: core %0d task %h, required core %0d task %h", c, t, ec, et);
      end
    end
    core_idle = '0; core_rdy = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_aging();
    test_miss();
    test_reset_mid_offer();
    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
